// File: rtl/ps2_keycode_if.sv
// Keyboard-line and keycode bus bundle for ps2_keycode.
// slave is the decoder side, master is whoever drives the PS/2 lines and reads the result.
interface ps2_keycode_if;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic [7:0] keycode;
  logic       key_event;
  logic       frame_err;

  modport master (
    output PS2_CLK,
    output PS2_DATA,
    input  keycode,
    input  key_event,
    input  frame_err
  );

  modport slave (
    input  PS2_CLK,
    input  PS2_DATA,
    output keycode,
    output key_event,
    output frame_err
  );
endinterface

// File: rtl/ps2_keycode.sv
// PS/2 scan-code set 2 receiver: synchronize, deglitch, frame, and translate the held
// key into a HID usage code with one-cycle change and error pulses.
module ps2_keycode #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 50000
) (
  input logic           Clk,
  input logic           Reset,
  ps2_keycode_if.slave  bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Returns {mapped, hid}; anything not listed is unmapped.
  function automatic logic [8:0] f_xlate(input logic ext, input logic [7:0] code);
    logic [8:0] r;
    r = 9'h000;
    case ({ext, code})
      9'h01C: r = 9'h104;
      9'h023: r = 9'h107;
      9'h01B: r = 9'h116;
      9'h01D: r = 9'h11A;
      9'h029: r = 9'h12C;
      9'h05A: r = 9'h128;
      9'h076: r = 9'h129;
      9'h175: r = 9'h152;
      9'h172: r = 9'h151;
      9'h16B: r = 9'h150;
      9'h174: r = 9'h14F;
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic [FW-1:0] r_fcnt;
  logic          r_fclk, r_fclk_prev;
  state_t        r_state;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_tcnt;
  logic          r_ext, r_brk;
  logic [7:0]    r_keycode;
  logic          r_key_event, r_frame_err;

  logic          w_fall;
  logic          w_bit;
  logic [8:0]    w_xl;

  assign w_fall = r_fclk_prev & ~r_fclk;
  assign w_bit  = r_dat_s2;
  assign w_xl   = f_xlate(r_ext, r_shift);

  // Synchronizers and clock filter: fclk follows only a level held FILTER_LEN samples.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_clk_s1    <= 1'b1;
      r_clk_s2    <= 1'b1;
      r_dat_s1    <= 1'b1;
      r_dat_s2    <= 1'b1;
      r_fcnt      <= '0;
      r_fclk      <= 1'b1;
      r_fclk_prev <= 1'b1;
    end else begin
      r_clk_s1    <= bus.PS2_CLK;
      r_clk_s2    <= r_clk_s1;
      r_dat_s1    <= bus.PS2_DATA;
      r_dat_s2    <= r_dat_s1;
      r_fclk_prev <= r_fclk;
      if (r_clk_s2 == r_fclk) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
        r_fclk <= r_clk_s2;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  // Frame FSM, inter-edge timeout and prefix-aware byte decoder.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_tcnt      <= '0;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_keycode   <= 8'h00;
      r_key_event <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_key_event <= 1'b0;
      r_frame_err <= 1'b0;

      if (r_state == S_IDLE || w_fall)
        r_tcnt <= '0;
      else if (r_tcnt != TW'(TIMEOUT))
        r_tcnt <= r_tcnt + 1'b1;

      if (r_state != S_IDLE && r_tcnt == TW'(TIMEOUT)) begin
        r_state     <= S_IDLE;
        r_frame_err <= 1'b1;
        r_ext       <= 1'b0;
        r_brk       <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_fall && !w_bit) begin
              r_bitcnt <= '0;
              r_state  <= S_DATA;
            end
          end
          S_DATA: begin
            if (w_fall) begin
              r_shift  <= {w_bit, r_shift[7:1]};
              r_bitcnt <= r_bitcnt + 1'b1;
              if (r_bitcnt == 3'd7)
                r_state <= S_PARITY;
            end
          end
          S_PARITY: begin
            if (w_fall) begin
              r_par   <= w_bit;
              r_state <= S_STOP;
            end
          end
          S_STOP: begin
            if (w_fall) begin
              r_state <= S_IDLE;
              if (w_bit && (^{r_shift, r_par})) begin
                if (r_shift == 8'hE0) begin
                  r_ext <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                  r_brk <= 1'b1;
                end else begin
                  r_ext <= 1'b0;
                  r_brk <= 1'b0;
                  // Repeat of the held key and release of a non-held key are both silent.
                  if (w_xl[8]) begin
                    if (!r_brk && w_xl[7:0] != r_keycode) begin
                      r_keycode   <= w_xl[7:0];
                      r_key_event <= 1'b1;
                    end else if (r_brk && w_xl[7:0] == r_keycode) begin
                      r_keycode   <= 8'h00;
                      r_key_event <= 1'b1;
                    end
                  end
                end
              end else begin
                r_frame_err <= 1'b1;
                r_ext       <= 1'b0;
                r_brk       <= 1'b0;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.keycode   = r_keycode;
  assign bus.key_event = r_key_event;
  assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_ps2_keycode.sv
// Scoreboard bench for ps2_keycode: frames are bit-banged on the PS/2 lines, a reference
// model queues the expected pulses and a monitor pops them as the DUT produces them.
module tb_ps2_keycode;
  localparam int FL   = 4;
  localparam int TO   = 200;
  localparam int HALF = 20;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  ps2_keycode_if bus();

  ps2_keycode #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       err;
    logic [7:0] code;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] m_key = 8'h00;
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  bit         in_reset = 1'b0;
  logic [7:0] prev_key = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [8:0] ref_map(input logic ext, input logic [7:0] b);
    if (!ext) begin
      case (b)
        8'h1C: return 9'h104;
        8'h23: return 9'h107;
        8'h1B: return 9'h116;
        8'h1D: return 9'h11A;
        8'h29: return 9'h12C;
        8'h5A: return 9'h128;
        8'h76: return 9'h129;
        default: return 9'h000;
      endcase
    end else begin
      case (b)
        8'h75: return 9'h152;
        8'h72: return 9'h151;
        8'h6B: return 9'h150;
        8'h74: return 9'h14F;
        default: return 9'h000;
      endcase
    end
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit good);
    logic [8:0] m;
    if (!good) begin
      exp_q.push_back('{err: 1'b1, code: 8'h00});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      m = ref_map(m_ext, b);
      if (m[8] && !m_brk && m[7:0] != m_key) begin
        m_key = m[7:0];
        exp_q.push_back('{err: 1'b0, code: m_key});
      end else if (m[8] && m_brk && m[7:0] == m_key) begin
        m_key = 8'h00;
        exp_q.push_back('{err: 1'b0, code: 8'h00});
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic drive_bit(input logic v, input bit glitch);
    bus.PS2_DATA = v;
    cyc(5);
    if (glitch) begin
      bus.PS2_CLK = 1'b0;
      cyc(2);
      bus.PS2_CLK = 1'b1;
    end
    cyc(HALF - 5);
    bus.PS2_CLK = 1'b0;
    cyc(HALF);
    bus.PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int glitch_bit);
    logic [10:0] bits;
    model_byte(b, !bad_par);
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) drive_bit(bits[i], i == glitch_bit);
    bus.PS2_DATA = 1'b1;
    cyc(4 * HALF);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, -1);
  endtask

  // Monitor: every pulse must match the head of the queue; keycode never moves silently.
  always @(negedge Clk) begin
    exp_t e;
    if (!in_reset && !Reset) begin
      if (bus.key_event || bus.frame_err) begin
        chk("evt_exclusive", {31'd0, bus.key_event & bus.frame_err}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_evt", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("evt_kind", {31'd0, bus.frame_err}, {31'd0, e.err});
          if (!e.err) chk("evt_code", {24'd0, bus.keycode}, {24'd0, e.code});
          else        chk("err_key_held", {24'd0, bus.keycode}, {24'd0, prev_key});
        end
      end else if (bus.keycode !== prev_key) begin
        chk("silent_key_change", {24'd0, bus.keycode}, {24'd0, prev_key});
      end
    end
    prev_key = bus.keycode;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;
    bus.PS2_CLK  = 1'b1;
    bus.PS2_DATA = 1'b1;
    Reset = 1'b1;
    cyc(5);
    chk("rst_keycode", {24'd0, bus.keycode}, 32'h00);
    chk("rst_key_event", {31'd0, bus.key_event}, 32'd0);
    chk("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    Reset = 1'b0;
    cyc(10);

    send(8'h1C);
    chk("make_1C", {24'd0, bus.keycode}, 32'h04);
    send(8'h1C);
    chk("repeat_1C", {24'd0, bus.keycode}, 32'h04);
    send(8'hF0); send(8'h1C);
    chk("break_1C", {24'd0, bus.keycode}, 32'h00);

    send(8'hE0); send(8'h75);
    chk("ext_make_75", {24'd0, bus.keycode}, 32'h52);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext_break_75", {24'd0, bus.keycode}, 32'h00);

    send(8'h1C); send(8'h23);
    chk("overlap_23", {24'd0, bus.keycode}, 32'h07);
    send(8'hF0); send(8'h1C);
    chk("release_other", {24'd0, bus.keycode}, 32'h07);
    send(8'hF0); send(8'h23);
    chk("release_23", {24'd0, bus.keycode}, 32'h00);

    send(8'h23);
    send_frame(8'h1C, 1'b1, -1);
    chk("parity_err_hold", {24'd0, bus.keycode}, 32'h07);
    send(8'h1D);
    chk("after_parity_1D", {24'd0, bus.keycode}, 32'h1A);

    // Timeout: start bit plus 4 data bits, then PS2_CLK stays high.
    model_byte(8'h00, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    bus.PS2_DATA = 1'b1;
    cyc(HALF);
    bus.PS2_CLK = 1'b0;
    seen = 1'b0;
    n = 0;
    for (int k = 1; k <= 2 * TO + 100 && !seen; k++) begin
      @(negedge Clk);
      if (k == HALF) bus.PS2_CLK = 1'b1;
      if (bus.frame_err) begin
        seen = 1'b1;
        n = k;
      end
    end
    if (!seen) chk("timeout_seen", {31'd0, bus.frame_err}, 32'd1);
    else chk("timeout_latency", {31'd0, (n >= TO + FL + 3) && (n <= TO + FL + 7)}, 32'd1);
    cyc(4 * HALF);
    chk("timeout_hold", {24'd0, bus.keycode}, 32'h1A);
    send(8'h1B);
    chk("after_timeout_1B", {24'd0, bus.keycode}, 32'h16);

    send_frame(8'h29, 1'b0, 3);
    chk("glitch_29", {24'd0, bus.keycode}, 32'h2C);

    // Reset mid-frame with the extended prefix pending.
    send(8'hE0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    in_reset = 1'b1;
    Reset = 1'b1;
    cyc(2);
    chk("midrst_keycode", {24'd0, bus.keycode}, 32'h00);
    chk("midrst_key_event", {31'd0, bus.key_event}, 32'd0);
    chk("midrst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    Reset = 1'b0;
    bus.PS2_DATA = 1'b1;
    m_key = 8'h00;
    m_ext = 1'b0;
    m_brk = 1'b0;
    exp_q.delete();
    cyc(2);
    in_reset = 1'b0;
    cyc(4 * HALF);
    send(8'h75);
    chk("prefix_lost_75", {24'd0, bus.keycode}, 32'h00);
    send(8'h1C);
    chk("post_reset_1C", {24'd0, bus.keycode}, 32'h04);

    cyc(50);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_keycode.md
# ps2_keycode

Receives serial PS/2 scan-code set 2 frames from the keyboard lines, filters and decodes them, and presents the currently held key as an 8-bit USB-HID-style usage code on `keycode`. It is the producer side of the `keycode` bus consumed by the game-object movement logic (A=8'h04, D=8'h07, S=8'h16, W=8'h1A). It holds the code while the key is down and returns it to 8'h00 on release.

## Interface
- `FILTER_LEN`, default 4: number of consecutive identical synchronized samples required before the filtered PS/2 clock changes.
- `TIMEOUT`, default 50000: Clk cycles allowed between filtered PS/2 falling edges inside a frame before the frame is aborted.
- `Clk`, in, 1: system clock. This is the only clock.
- `Reset`, in, 1: synchronous, active-high reset.
- `PS2_CLK`, in, 1: keyboard clock. Asynchronous, idles high.
- `PS2_DATA`, in, 1: keyboard data. Asynchronous, idles high.
- `keycode`, out, 8: translated code of the held key; 8'h00 when no key is held.
- `key_event`, out, 1: one-cycle pulse asserted in the same cycle `keycode` changes value.
- `frame_err`, out, 1: one-cycle pulse on a parity, stop-bit, or timeout error.

## Operation
- **Input conditioning**
  - `PS2_CLK` and `PS2_DATA` each pass through a 2-flop synchronizer.
  - Filtered clock `fclk` takes the synchronized value only after `FILTER_LEN` identical consecutive samples.
  - A falling edge of `fclk` is one cycle with `fclk_prev`=1 and `fclk`=0. It samples the synchronized data.
- **Frame FSM**, states IDLE, DATA, PARITY, STOP:
  - IDLE: on a falling edge with data=0 (start bit), clear the bit count and go to DATA. A falling edge with data=1 is ignored and the FSM stays in IDLE.
  - DATA: shift in 8 bits LSB first. After bit 8, go to PARITY.
  - PARITY: latch the bit and go to STOP. The frame is good when data XOR parity has odd parity (total ones across data and parity is odd).
  - STOP: sample the stop bit. If stop=1 and parity is good, the byte is accepted. Otherwise pulse `frame_err`. Return to IDLE in both cases.
  - Timeout: a counter of width clog2(TIMEOUT+1) clears on every falling edge and in IDLE. When it reaches `TIMEOUT` in DATA, PARITY, or STOP, go to IDLE, pulse `frame_err`, and discard the partial byte.
- **Byte decoder**, prefix flags `ext` (E0 seen) and `brk` (F0 seen):
  - 8'hE0 sets `ext`. 8'hF0 sets `brk`. Neither changes the outputs.
  - Any other byte is looked up with `ext`, then both flags clear.
  - Any frame error also clears both flags.
- **Translation table** (all other codes are unmapped):
  - Non-extended: 1C→04, 23→07, 1B→16, 1D→1A, 29→2C, 5A→28, 76→29.
  - Extended: 75→52, 72→51, 6B→50, 74→4F.
- **Make code (mapped)**
  - If the HID code differs from `keycode`: load it and pulse `key_event`.
  - If it is equal (typematic repeat): no change and no pulse.
- **Break code (mapped)**
  - If the HID code equals `keycode`: set `keycode`=00 and pulse `key_event`.
  - Otherwise (release of a non-current key): ignored.
- Unmapped make or break codes are ignored.

## Timing
- **Reset values:** `keycode`=00, `key_event`=0, `frame_err`=0. Internally, the FSM is IDLE, flags are clear, the counters are 0, `fclk` and `fclk_prev` are 1, and the synchronizers are 1.
- **Edge detection latency:** a `PS2_CLK` falling edge is detected 2 (sync) + `FILTER_LEN` cycles after the pin changes.
- **Output latency:** `keycode`/`key_event` update on the cycle after the stop-bit falling edge is detected. `frame_err` asserts at that same point, or on the timeout cycle.
- **Pulse widths:** `key_event` and `frame_err` are exactly 1 cycle. They are never asserted together.
- **Glitches:** pulses on `PS2_CLK` shorter than `FILTER_LEN` cycles produce no edge.
- **Reset mid-frame:** Reset takes priority in any state. The partial frame and prefix flags are lost and no error pulse is produced.
- **Bench signaling rate:** assume a 50 MHz `Clk` and a PS/2 bit period of about 60-100 µs.

## Test plan
- **Basic make/repeat/break:**
  - Frame 1C → `keycode`=04 with one `key_event` pulse.
  - Repeat 1C → no pulse.
  - F0 then 1C → `keycode`=00 with one pulse.
- **Extended key:**
  - E0 75 → `keycode`=52.
  - E0 F0 75 → `keycode`=00.
- **Key overlap:**
  - 1C, then 23 → `keycode`=07.
  - F0 1C → unchanged 07, no pulse.
  - F0 23 → 00.
- **Parity error:** 1C sent with bad parity → `frame_err` pulse, `keycode` unchanged. The next good 1D → 1A.
- **Timeout:**
  - Stop `PS2_CLK` after 4 data bits → `frame_err` exactly `TIMEOUT` cycles after the last edge.
  - A following frame 1B → 16.
- **Glitch and reset:**
  - A 2-cycle low glitch on `PS2_CLK` is ignored.
  - Reset asserted mid-frame → all outputs return to their reset values.
  - A subsequent 1C frame decodes to 04.
